ddr_req_sched: RTL and testbench

DDR_REQ_SCHED -- requirements
Module: ddr_req_sched

---
 rtl/ddr_req_sched_if.sv | 26 ++
 rtl/ddr_req_sched.sv | 147 ++++++++++++++
 tb/tb_ddr_req_sched.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_req_sched_if.sv
// FIFO-side and DDR-command-side signals of the request scheduler.
// The master modport is the scheduler's view; the slave modport is the environment's.
interface ddr_req_sched_if;
   logic [2:0]  ch_empty_i;
   logic [2:0]  ch_valid_i;
   logic [44:0] ch_dout0_i;
   logic [44:0] ch_dout1_i;
   logic [44:0] ch_dout2_i;
   logic [2:0]  ch_rd_en_o;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic [29:0] cmd_addr_o;
   logic        cmd_wr_o;
   logic [14:0] cmd_tag_o;
   logic        cmd_last_o;

   modport master (
      input  ch_empty_i, ch_valid_i, ch_dout0_i, ch_dout1_i, ch_dout2_i, cmd_ready_i,
      output ch_rd_en_o, cmd_valid_o, cmd_addr_o, cmd_wr_o, cmd_tag_o, cmd_last_o
   );

   modport slave (
      output ch_empty_i, ch_valid_i, ch_dout0_i, ch_dout1_i, ch_dout2_i, cmd_ready_i,
      input  ch_rd_en_o, cmd_valid_o, cmd_addr_o, cmd_wr_o, cmd_tag_o, cmd_last_o
   );
endinterface

// File: rtl/ddr_req_sched.sv
// Round-robin scheduler: pops one entry from one of three request FIFOs and
// expands it into BURST_NUM DDR commands at ADDR_STEP spacing.
module ddr_req_sched #(
   parameter int unsigned BURST_NUM = 16,
   parameter logic [29:0] ADDR_STEP = 30'd64,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sched_en_i,
   ddr_req_sched_if.master       bus,
   output logic [2:0]            grant_o,
   output logic                  busy_o,
   output logic                  err_timeout_o
);

   typedef enum logic [1:0] {IDLE, POP, WAIT_VLD, ISSUE} state_e;

   localparam logic [7:0] BEAT_LAST = 8'(BURST_NUM - 1);
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_e      state_q;
   logic [1:0]  rr_q;
   logic [1:0]  gidx_q;
   logic [2:0]  grant_q;
   logic [2:0]  rd_en_q;
   logic [7:0]  wait_q;
   logic [7:0]  beat_q;
   logic        cmd_valid_q;
   logic        wr_q;
   logic        last_q;
   logic        err_q;
   logic [29:0] addr_q;
   logic [14:0] tag_q;

   logic [1:0]  sel_d;
   logic        sel_ok_d;
   logic [1:0]  cand;
   logic [44:0] ent;
   logic        vld_g;

   // Search starts just after the last granted channel and wraps back to it.
   always_comb begin
      sel_d    = '0;
      sel_ok_d = 1'b0;
      cand     = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
      for (int unsigned i = 0; i < 3; i++) begin
         if (!sel_ok_d && !bus.ch_empty_i[cand]) begin
            sel_d    = cand;
            sel_ok_d = 1'b1;
         end
         cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
      end
   end

   always_comb begin
      case (gidx_q)
         2'd1:    begin ent = bus.ch_dout1_i; vld_g = bus.ch_valid_i[1]; end
         2'd2:    begin ent = bus.ch_dout2_i; vld_g = bus.ch_valid_i[2]; end
         default: begin ent = bus.ch_dout0_i; vld_g = bus.ch_valid_i[0]; end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_q        <= 2'd2;
         gidx_q      <= '0;
         grant_q     <= '0;
         rd_en_q     <= '0;
         wait_q      <= '0;
         beat_q      <= '0;
         cmd_valid_q <= 1'b0;
         wr_q        <= 1'b0;
         last_q      <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         tag_q       <= '0;
      end else begin
         rd_en_q <= '0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (sched_en_i && sel_ok_d) begin
                  gidx_q  <= sel_d;
                  rr_q    <= sel_d;
                  grant_q <= 3'b001 << sel_d;
                  rd_en_q <= 3'b001 << sel_d;
                  state_q <= POP;
               end
            end
            POP: begin
               wait_q  <= '0;
               state_q <= WAIT_VLD;
            end
            WAIT_VLD: begin
               if (vld_g) begin
                  if (ent[0]) begin
                     addr_q      <= ent[44:15];
                     wr_q        <= ent[1];
                     tag_q       <= {ent[14:2], gidx_q};
                     beat_q      <= '0;
                     last_q      <= (BEAT_LAST == 8'd0);
                     cmd_valid_q <= 1'b1;
                     state_q     <= ISSUE;
                  end else begin
                     grant_q <= '0;
                     state_q <= IDLE;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  err_q   <= 1'b1;
                  grant_q <= '0;
                  state_q <= IDLE;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            ISSUE: begin
               if (bus.cmd_ready_i) begin
                  if (last_q) begin
                     cmd_valid_q <= 1'b0;
                     last_q      <= 1'b0;
                     grant_q     <= '0;
                     state_q     <= IDLE;
                  end else begin
                     beat_q <= beat_q + 8'd1;
                     addr_q <= addr_q + ADDR_STEP;
                     last_q <= ((beat_q + 8'd1) == BEAT_LAST);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ch_rd_en_o  = rd_en_q;
   assign bus.cmd_valid_o = cmd_valid_q;
   assign bus.cmd_addr_o  = addr_q;
   assign bus.cmd_wr_o    = wr_q;
   assign bus.cmd_tag_o   = tag_q;
   assign bus.cmd_last_o  = last_q;
   assign grant_o         = grant_q;
   assign busy_o          = (state_q != IDLE);
   assign err_timeout_o   = err_q;

endmodule

// File: tb/tb_ddr_req_sched.sv
// Bench for ddr_req_sched: queue-based FIFO responder, bus monitor, and
// per-scenario tasks comparing against a queue/arithmetic reference model.
module tb_ddr_req_sched;
   localparam int unsigned BN   = 16;
   localparam logic [29:0] STEP = 30'd64;
   localparam int unsigned TO   = 15;

   typedef struct packed {
      logic [29:0] addr;
      logic        wr;
      logic [14:0] tag;
      logic        last;
   } cmd_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sched_en = 1'b0;
   logic       ready = 1'b0;
   logic [2:0] grant;
   logic       busy;
   logic       err;

   ddr_req_sched_if bus ();

   ddr_req_sched #(.BURST_NUM(BN), .ADDR_STEP(STEP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .sched_en_i(sched_en), .bus(bus),
      .grant_o(grant), .busy_o(busy), .err_timeout_o(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int stall_viol = 0;
   int pop_empty = 0;
   int err_busy = 0;

   logic [44:0] fq [3][$];
   cmd_t        got_cmd [$];
   int          got_grant [$];
   logic [2:0]  got_pop [$];
   int          pop_cyc [$];
   int          err_cyc [$];
   int          last_cyc [$];
   int          fall_cyc [$];

   logic [2:0]  mute_mask = '0;
   logic        noise = 1'b0;
   logic [2:0]  empty_r = '1;
   logic [2:0]  valid_r = '0;
   logic [44:0] dout_r [3];

   assign bus.ch_empty_i  = empty_r;
   assign bus.ch_valid_i  = valid_r;
   assign bus.ch_dout0_i  = dout_r[0];
   assign bus.ch_dout1_i  = dout_r[1];
   assign bus.ch_dout2_i  = dout_r[2];
   assign bus.cmd_ready_i = ready;

   function automatic logic [44:0] mk(logic v, logic w, logic [7:0] p1, logic [2:0] p2,
                                      logic [1:0] st, logic [29:0] a);
      return {a, st, p2, p1, w, v};
   endfunction

   // Command i of an entry: start + i*step reduced modulo 2^30.
   function automatic cmd_t exp_cmd(logic [44:0] e, int ch, int i);
      cmd_t r;
      longint unsigned a;
      a = (64'(e[44:15]) + 64'(i) * 64'(STEP)) % (64'd1 << 30);
      r.addr = a[29:0];
      r.wr   = e[1];
      r.tag  = {e[14:13], e[12:10], e[9:2], 2'(ch)};
      r.last = (i == int'(BN) - 1);
      return r;
   endfunction

   // FIFO model: read data valid one cycle after the pop strobe.
   initial begin
      int pend;
      logic [44:0] pend_e;
      pend = -1;
      pend_e = '0;
      for (int c = 0; c < 3; c++) dout_r[c] = '0;
      forever begin
         @(posedge clk);
         #1;
         valid_r = '0;
         if (rst) pend = -1;
         else begin
            if (pend >= 0) begin
               if (!mute_mask[pend]) begin
                  valid_r[pend] = 1'b1;
                  dout_r[pend] = pend_e;
               end
               pend = -1;
            end
            for (int c = 0; c < 3; c++)
               if (bus.ch_rd_en_o[c]) begin
                  if (fq[c].size() > 0) begin
                     pend_e = fq[c].pop_front();
                     pend = c;
                  end else pop_empty++;
               end
            if (noise)
               for (int c = 0; c < 3; c++)
                  if (!grant[c] && $urandom_range(0, 3) == 0) begin
                     valid_r[c] = 1'b1;
                     dout_r[c] = 45'({$urandom(), $urandom()}) | 45'd1;
                  end
         end
         for (int c = 0; c < 3; c++) empty_r[c] = (fq[c].size() == 0);
      end
   end

   // Monitor: records handshakes, grants, pops, timeouts and stall stability.
   initial begin
      cmd_t cur, prev_cmd;
      logic prev_stall;
      logic [2:0] prev_g;
      int gi;
      prev_stall = 1'b0;
      prev_g = '0;
      prev_cmd = '0;
      forever begin
         @(negedge clk);
         cyc++;
         cur = {bus.cmd_addr_o, bus.cmd_wr_o, bus.cmd_tag_o, bus.cmd_last_o};
         if (!rst) begin
            if (prev_stall && (!bus.cmd_valid_o || cur != prev_cmd)) stall_viol++;
            if (bus.cmd_valid_o && ready) begin
               got_cmd.push_back(cur);
               if (bus.cmd_last_o) last_cyc.push_back(cyc);
            end
            gi = (grant == 3'b001) ? 0 : (grant == 3'b010) ? 1 : (grant == 3'b100) ? 2 : 9;
            if (grant != 3'b000 && prev_g == 3'b000) got_grant.push_back(gi);
            if (grant == 3'b000 && prev_g != 3'b000) fall_cyc.push_back(cyc);
            if (bus.ch_rd_en_o != 3'b000) begin
               got_pop.push_back(bus.ch_rd_en_o);
               pop_cyc.push_back(cyc);
            end
            if (err) begin
               err_cyc.push_back(cyc);
               if (busy) err_busy++;
            end
         end
         prev_stall = !rst && bus.cmd_valid_o && !ready;
         prev_cmd = cur;
         prev_g = rst ? 3'b000 : grant;
      end
   end

   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic clear_mon();
      got_cmd.delete(); got_grant.delete(); got_pop.delete(); pop_cyc.delete();
      err_cyc.delete(); last_cyc.delete(); fall_cyc.delete();
      stall_viol = 0; pop_empty = 0; err_busy = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1; sched_en = 1'b0; ready = 1'b0; mute_mask = '0; noise = 1'b0;
      for (int c = 0; c < 3; c++) fq[c].delete();
      tick(); tick();
      clear_mon();
      rst = 1'b0;
   endtask

   // rmode: 0 ready always high, 1 random ready, 2 ready one cycle in three.
   task automatic wait_idle(input int maxc, input int rmode, input bit ren, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < maxc; k++) begin
         case (rmode)
            0:       ready = 1'b1;
            1:       ready = ($urandom_range(0, 4) < 3);
            default: ready = (k % 3 == 2);
         endcase
         if (ren) sched_en = ($urandom_range(0, 4) != 0);
         tick();
         if (!busy && fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; sched_en = 1'b1; ready = 1'b1;
      fq[0].push_back(mk(1'b1, 1'b0, 8'h11, 3'd1, 2'd1, 30'h100));
      repeat (3) tick();
      n_checks++;
      if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant: got %b expected 000", grant); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (bus.ch_rd_en_o !== 3'b000) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 000", bus.ch_rd_en_o); end
      n_checks++;
      if (bus.cmd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", bus.cmd_valid_o); end
      n_checks++;
      if ({bus.cmd_addr_o, bus.cmd_wr_o, bus.cmd_tag_o, bus.cmd_last_o, err} !== 48'd0) begin
         n_fail++;
         $display("FAIL reset_payload: got addr=%h wr=%b tag=%h last=%b err=%b expected all 0",
                  bus.cmd_addr_o, bus.cmd_wr_o, bus.cmd_tag_o, bus.cmd_last_o, err);
      end
      do_reset();
   endtask

   task automatic test_single_burst();
      logic [44:0] e;
      cmd_t x;
      bit ok;
      do_reset();
      e = mk(1'b1, 1'b0, 8'h5A, 3'd3, 2'd2, 30'h1000_0000);
      fq[0].push_back(e);
      sched_en = 1'b1;
      wait_idle(400, 0, 1'b0, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL single_done: got timeout expected idle"); end
      n_checks++;
      if (got_cmd.size() != int'(BN)) begin n_fail++; $display("FAIL single_count: got %0d expected %0d", got_cmd.size(), BN); end
      for (int i = 0; i < got_cmd.size() && i < int'(BN); i++) begin
         x = exp_cmd(e, 0, i);
         n_checks++;
         if (got_cmd[i] !== x || got_cmd[i].addr !== 30'h1000_0000 + 30'(i * 64)) begin
            n_fail++;
            $display("FAIL single_cmd%0d: got %h expected %h", i, got_cmd[i], x);
         end
      end
      n_checks++;
      if (got_pop.size() != 1 || got_pop[0] !== 3'b001) begin n_fail++; $display("FAIL single_pop: got %0d pops expected one on ch0", got_pop.size()); end
      n_checks++;
      if (last_cyc.size() != 1 || fall_cyc.size() != 1 || fall_cyc[0] - last_cyc[0] != 1) begin
         n_fail++;
         $display("FAIL single_idle_after_last: got %0d/%0d events expected grant drop 1 cycle after last", last_cyc.size(), fall_cyc.size());
      end
   endtask

   task automatic test_round_robin();
      int exp_g [6] = '{0, 1, 2, 0, 1, 2};
      bit ok;
      do_reset();
      for (int c = 0; c < 3; c++)
         for (int k = 0; k < 2; k++)
            fq[c].push_back(mk(1'b1, 1'(k), 8'(c * 16 + k), 3'(c), 2'(k), 30'(c * 'h10000 + k * 'h1000)));
      sched_en = 1'b1;
      wait_idle(1000, 0, 1'b0, ok);
      n_checks++;
      if (!ok || got_grant.size() != 6) begin n_fail++; $display("FAIL rr_grants: got %0d grants expected 6", got_grant.size()); end
      for (int i = 0; i < 6 && i < got_grant.size() && i < got_pop.size(); i++) begin
         n_checks++;
         if (got_grant[i] != exp_g[i] || got_pop[i] !== 3'(1 << exp_g[i])) begin
            n_fail++;
            $display("FAIL rr_order%0d: got ch%0d pop %b expected ch%0d", i, got_grant[i], got_pop[i], exp_g[i]);
         end
      end
      n_checks++;
      if (got_pop.size() != 6 || got_cmd.size() != 6 * int'(BN)) begin
         n_fail++;
         $display("FAIL rr_totals: got %0d pops %0d cmds expected 6 and %0d", got_pop.size(), got_cmd.size(), 6 * BN);
      end
   endtask

   task automatic test_stall();
      logic [44:0] e;
      cmd_t x;
      bit ok;
      do_reset();
      e = mk(1'b1, 1'b1, 8'hC3, 3'd5, 2'd3, 30'h0ABC_0040);
      fq[2].push_back(e);
      sched_en = 1'b1;
      wait_idle(600, 2, 1'b0, ok);
      n_checks++;
      if (!ok || got_cmd.size() != int'(BN)) begin n_fail++; $display("FAIL stall_count: got %0d handshakes expected %0d", got_cmd.size(), BN); end
      n_checks++;
      if (stall_viol != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", stall_viol); end
      for (int i = 0; i < got_cmd.size() && i < int'(BN); i++) begin
         x = exp_cmd(e, 2, i);
         n_checks++;
         if (got_cmd[i] !== x) begin n_fail++; $display("FAIL stall_cmd%0d: got %h expected %h", i, got_cmd[i], x); end
      end
   endtask

   task automatic test_addr_wrap();
      bit ok;
      do_reset();
      fq[1].push_back(mk(1'b1, 1'b0, 8'h01, 3'd0, 2'd0, 30'h3FFF_FFC0));
      sched_en = 1'b1;
      wait_idle(400, 0, 1'b0, ok);
      n_checks++;
      if (!ok || got_cmd.size() != int'(BN)) begin n_fail++; $display("FAIL wrap_count: got %0d expected %0d", got_cmd.size(), BN); end
      else begin
         n_checks++;
         if (got_cmd[0].addr !== 30'h3FFF_FFC0) begin n_fail++; $display("FAIL wrap_first: got %h expected 3fffffc0", got_cmd[0].addr); end
         n_checks++;
         if (got_cmd[1].addr !== 30'h0000_0000) begin n_fail++; $display("FAIL wrap_second: got %h expected 0", got_cmd[1].addr); end
         n_checks++;
         if (got_cmd[15].addr !== 30'h0000_0380) begin n_fail++; $display("FAIL wrap_last: got %h expected 380", got_cmd[15].addr); end
      end
   endtask

   task automatic test_timeout_drop();
      logic [44:0] e1, e0;
      bit ok;
      do_reset();
      mute_mask = 3'b001;
      e1 = mk(1'b1, 1'b1, 8'h22, 3'd2, 2'd1, 30'h0200_0000);
      fq[0].push_back(mk(1'b1, 1'b0, 8'h33, 3'd3, 2'd3, 30'h0300_0000));
      fq[1].push_back(e1);
      sched_en = 1'b1;
      wait_idle(600, 0, 1'b0, ok);
      n_checks++;
      if (!ok || err_cyc.size() != 1 || pop_cyc.size() == 0) begin
         n_fail++;
         $display("FAIL to_pulses: got %0d pulses expected 1", err_cyc.size());
      end else begin
         n_checks++;
         if (err_cyc[0] - pop_cyc[0] != int'(TO) + 1) begin
            n_fail++;
            $display("FAIL to_latency: got %0d expected %0d", err_cyc[0] - pop_cyc[0], TO + 1);
         end
      end
      n_checks++;
      if (err_busy != 0) begin n_fail++; $display("FAIL to_idle: got busy at pulse %0d times expected 0", err_busy); end
      n_checks++;
      if (got_grant.size() != 2 || got_grant[0] != 0 || got_grant[1] != 1) begin
         n_fail++;
         $display("FAIL to_next_grant: got %0d grants expected ch0 then ch1", got_grant.size());
      end
      n_checks++;
      if (got_cmd.size() != int'(BN) || got_cmd[0] !== exp_cmd(e1, 1, 0)) begin
         n_fail++;
         $display("FAIL to_cmds: got %0d expected %0d from ch1", got_cmd.size(), BN);
      end
      mute_mask = '0;
      clear_mon();
      e0 = mk(1'b1, 1'b0, 8'h44, 3'd4, 2'd0, 30'h0400_0000);
      fq[2].push_back(mk(1'b0, 1'b1, 8'h55, 3'd5, 2'd2, 30'h0500_0000));
      fq[0].push_back(e0);
      wait_idle(600, 0, 1'b0, ok);
      n_checks++;
      if (!ok || got_grant.size() != 2 || got_grant[0] != 2 || got_grant[1] != 0) begin
         n_fail++;
         $display("FAIL drop_grants: got %0d grants expected ch2 then ch0", got_grant.size());
      end
      n_checks++;
      if (got_cmd.size() != int'(BN) || got_cmd[0] !== exp_cmd(e0, 0, 0) || err_cyc.size() != 0) begin
         n_fail++;
         $display("FAIL drop_cmds: got %0d cmds %0d errs expected %0d and 0", got_cmd.size(), err_cyc.size(), BN);
      end
   endtask

   task automatic test_reset_mid();
      logic [44:0] e;
      bit ok;
      int k;
      do_reset();
      fq[0].push_back(mk(1'b1, 1'b1, 8'h77, 3'd7, 2'd1, 30'h0123_4000));
      sched_en = 1'b1; ready = 1'b1;
      k = 0;
      while (got_cmd.size() < 4 && k < 100) begin tick(); k++; end
      n_checks++;
      if (bus.cmd_valid_o !== 1'b1 || got_cmd.size() != 4) begin
         n_fail++;
         $display("FAIL mid_active: got valid=%b cmds=%0d expected 1 and 4", bus.cmd_valid_o, got_cmd.size());
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.ch_rd_en_o, bus.cmd_valid_o, bus.cmd_addr_o, bus.cmd_wr_o, bus.cmd_tag_o,
           bus.cmd_last_o, grant, busy, err} !== 56'd0) begin
         n_fail++;
         $display("FAIL mid_async_clear: got valid=%b addr=%h grant=%b busy=%b expected all 0",
                  bus.cmd_valid_o, bus.cmd_addr_o, grant, busy);
      end
      tick(); tick();
      rst = 1'b0;
      repeat (30) tick();
      n_checks++;
      if (got_cmd.size() != 4 || got_pop.size() != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_no_resume: got %0d cmds %0d pops busy=%b expected 4 1 0", got_cmd.size(), got_pop.size(), busy);
      end
      e = mk(1'b1, 1'b0, 8'h88, 3'd0, 2'd2, 30'h0765_0000);
      fq[1].push_back(e);
      wait_idle(400, 0, 1'b0, ok);
      n_checks++;
      if (!ok || got_cmd.size() != 4 + int'(BN) || got_cmd[4] !== exp_cmd(e, 1, 0)) begin
         n_fail++;
         $display("FAIL mid_new_entry: got %0d cmds expected %0d starting at new entry", got_cmd.size(), 4 + BN);
      end
   endtask

   task automatic test_random();
      logic [44:0] sq [3][$];
      logic [44:0] e;
      int exp_g [$];
      cmd_t exp_c [$];
      int rr, c;
      bit ok;
      for (int it = 0; it < 3; it++) begin
         do_reset();
         noise = 1'b1;
         for (int ch = 0; ch < 3; ch++) begin
            sq[ch].delete();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
               e = mk($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), 3'($urandom), 2'($urandom),
                      ($urandom_range(0, 3) == 0) ? 30'h3FFF_FE00 | 30'($urandom_range(0, 15) << 6) : 30'($urandom));
               fq[ch].push_back(e);
               sq[ch].push_back(e);
            end
         end
         exp_g.delete();
         exp_c.delete();
         rr = 2;
         while (sq[0].size() + sq[1].size() + sq[2].size() > 0) begin
            for (int d = 1; d <= 3; d++) begin
               c = (rr + d) % 3;
               if (sq[c].size() > 0) begin
                  e = sq[c].pop_front();
                  exp_g.push_back(c);
                  if (e[0]) for (int i = 0; i < int'(BN); i++) exp_c.push_back(exp_cmd(e, c, i));
                  rr = c;
                  break;
               end
            end
         end
         wait_idle(4000, 1, 1'b1, ok);
         sched_en = 1'b0;
         n_checks++;
         if (!ok || got_grant.size() != exp_g.size() || got_pop.size() != exp_g.size()) begin
            n_fail++;
            $display("FAIL rand%0d_grants: got %0d grants %0d pops expected %0d", it, got_grant.size(), got_pop.size(), exp_g.size());
         end
         for (int i = 0; i < exp_g.size() && i < got_grant.size(); i++) begin
            n_checks++;
            if (got_grant[i] != exp_g[i]) begin n_fail++; $display("FAIL rand%0d_grant%0d: got %0d expected %0d", it, i, got_grant[i], exp_g[i]); end
         end
         n_checks++;
         if (got_cmd.size() != exp_c.size()) begin n_fail++; $display("FAIL rand%0d_cmd_count: got %0d expected %0d", it, got_cmd.size(), exp_c.size()); end
         for (int i = 0; i < exp_c.size() && i < got_cmd.size(); i++) begin
            n_checks++;
            if (got_cmd[i] !== exp_c[i]) begin n_fail++; $display("FAIL rand%0d_cmd%0d: got %h expected %h", it, i, got_cmd[i], exp_c[i]); end
         end
         n_checks++;
         if (stall_viol != 0 || pop_empty != 0 || err_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL rand%0d_protocol: got stall=%0d emptypop=%0d err=%0d expected 0 0 0", it, stall_viol, pop_empty, err_cyc.size());
         end
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_stall();
      test_addr_wrap();
      test_timeout_drop();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
